// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master: the datapath side (drives hazard inputs, consumes enables).
// slave:  the controller side.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] exe_rn;
  logic       exe_wreg;
  logic       exe_m2reg;
  logic       mem_m2reg;
  logic       mem_wmem;
  logic       dmem_ready;
  logic       branch_taken;
  logic       wpcir;
  logic       ifid_flush;
  logic       idexe_en;
  logic       idexe_bubble;
  logic       exemem_en;
  logic       memwb_bubble;
  logic       dmem_req;
  logic       busy_wait;
  logic       timeout_err;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
           mem_m2reg, mem_wmem, dmem_ready, branch_taken,
    input  wpcir, ifid_flush, idexe_en, idexe_bubble, exemem_en, memwb_bubble,
           dmem_req, busy_wait, timeout_err
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
           mem_m2reg, mem_wmem, dmem_ready, branch_taken,
    output wpcir, ifid_flush, idexe_en, idexe_bubble, exemem_en, memwb_bubble,
           dmem_req, busy_wait, timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squash and a memory-wait freeze with timeout guard.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                clr,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt,
`endif
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic {StRun = 1'b0, StWait = 1'b1} state_e;

  localparam logic [WAIT_W-1:0] MaxWaitC = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] OneC     = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic macc;
  logic at_max;
  logic memstall;
  logic rs_hit;
  logic rt_hit;
  logic lduse;

  logic wpcir;
  logic ifid_flush;
  logic idexe_en;
  logic idexe_bubble;
  logic exemem_en;
  logic memwb_bubble;
  logic dmem_req;

  assign macc     = hz.mem_m2reg | hz.mem_wmem;
  // On the last allowed wait cycle the access is abandoned, so no stall.
  assign at_max   = (state_q == StWait) && (wait_cnt_q == MaxWaitC);
  assign memstall = macc & ~hz.dmem_ready & ~at_max;

  assign rs_hit = hz.id_use_rs && (hz.id_rs == hz.exe_rn);
  assign rt_hit = hz.id_use_rt && (hz.id_rt == hz.exe_rn);
  assign lduse  = hz.exe_wreg && hz.exe_m2reg && (hz.exe_rn != 5'd0) && (rs_hit || rt_hit);

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic for the memory-wait FSM and the timeout flag.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StRun: begin
        if (macc && !hz.dmem_ready) begin
          state_d    = StWait;
          wait_cnt_d = OneC;
        end
      end
      StWait: begin
        // A dropped request is illegal but handled quietly.
        if (hz.dmem_ready || !macc) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (at_max) begin
          state_d       = StRun;
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + OneC;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline enables: memstall beats load-use beats branch squash.
  always_comb begin
    wpcir        = 1'b1;
    ifid_flush   = 1'b0;
    idexe_en     = 1'b1;
    idexe_bubble = 1'b0;
    exemem_en    = 1'b1;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;
    if (!clr) begin
      dmem_req = macc;
      if (memstall) begin
        wpcir        = 1'b0;
        idexe_en     = 1'b0;
        exemem_en    = 1'b0;
        memwb_bubble = 1'b1;
      end else if (lduse) begin
        // Branch is held in ID and re-resolves once the bubble is in.
        wpcir        = 1'b0;
        idexe_bubble = 1'b1;
      end else if (hz.branch_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign hz.wpcir        = wpcir;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idexe_en     = idexe_en;
  assign hz.idexe_bubble = idexe_bubble;
  assign hz.exemem_en    = exemem_en;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.dmem_req     = dmem_req;
  assign hz.busy_wait    = (state_q == StWait);
  assign hz.timeout_err  = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running wrap-around counters of stall and flush cycles.
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!wpcir) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives enables and bubbles for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Detects load-use hazards from ID vs EXE and squashes the wrong-path fetch on a taken branch.
- Freezes the pipe while a data-memory access in MEM is not yet ready, with a wait-timeout guard.

Parameters:
- WAIT_W, 4: width of the memory-wait cycle counter.
- MAX_WAIT, 15: wait cycles after which the controller gives up; must be ≤ 2^WAIT_W-1 and ≥ 1.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- clr  in  1  reset; one clock, reset is synchronous and active-high.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- exe_rn  in  5  destination register of instruction in EXE.
- exe_wreg  in  1  EXE instruction writes the register file.
- exe_m2reg  in  1  EXE instruction is a load.
- mem_m2reg  in  1  MEM instruction is a load.
- mem_wmem  in  1  MEM instruction is a store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- branch_taken  in  1  ID resolved a taken branch/jump.
- wpcir  out  1  write enable for PC and IF/ID.
- ifid_flush  out  1  load a NOP into IF/ID.
- idexe_en  out  1  ID/EXE write enable.
- idexe_bubble  out  1  load a bubble (wreg=m2reg=wmem=0) into ID/EXE.
- exemem_en  out  1  EXE/MEM write enable.
- memwb_bubble  out  1  load a bubble into MEM/WB.
- dmem_req  out  1  data-memory access request.
- busy_wait  out  1  high while the FSM is in WAIT.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Registered state: state ∈ {RUN=0, WAIT=1}, wait_cnt[WAIT_W-1:0], timeout_err. All other outputs are combinational from state and inputs.
- Reset values (clr=1 at a rising edge): state=RUN, wait_cnt=0, timeout_err=0.
- While clr=1, outputs are forced: wpcir=1, idexe_en=1, exemem_en=1, all flush/bubble=0, dmem_req=0.
- macc = mem_m2reg | mem_wmem; dmem_req = macc whenever clr=0.
- memstall = macc & ~dmem_ready & ~(state==WAIT & wait_cnt==MAX_WAIT).
- lduse = exe_wreg & exe_m2reg & (exe_rn≠0) & ((id_use_rs & id_rs==exe_rn) | (id_use_rt & id_rt==exe_rn)).
- Output priority:
  - memstall: wpcir=0, idexe_en=0, exemem_en=0, memwb_bubble=1, everything else 0. The whole front end is frozen.
  - else lduse: wpcir=0, idexe_en=1, idexe_bubble=1, exemem_en=1. ifid_flush=0 even if branch_taken; the branch re-evaluates next cycle. Exactly one bubble per hazard.
  - else branch_taken: wpcir=1, ifid_flush=1, all other enables 1.
  - else: all enables 1, all bubbles/flush 0.
- FSM transitions:
  - RUN→WAIT when macc & ~dmem_ready; wait_cnt←1.
  - WAIT→RUN when dmem_ready; wait_cnt←0.
  - WAIT and ~dmem_ready and wait_cnt<MAX_WAIT: wait_cnt+1.
  - WAIT and ~dmem_ready and wait_cnt==MAX_WAIT: timeout. memstall is deasserted that cycle (the access is abandoned and the pipe advances), timeout_err←1, state←RUN, wait_cnt←0.
  - WAIT and macc dropped (not legal): return to RUN, no error.
- Latency:
  - dmem_ready with no wait → zero extra cycles.
  - Each not-ready cycle costs exactly one stall cycle.
- busy_wait = (state==WAIT).
- timeout_err stays 1 until clr.
- clr in mid-WAIT: next state RUN, counter cleared, no error recorded.
- Simultaneous lduse and memstall: memstall wins. The load-use bubble is inserted on the first cycle after memstall clears, provided the hazard still holds.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 by clr.
  - stall_cnt increments in every cycle where wpcir=0.
  - flush_cnt increments in every cycle where ifid_flush=1.
  - Both counters wrap at 2^32.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: exe_wreg=1, exe_m2reg=1, exe_rn=5, id_rs=5, id_use_rs=1, dmem_ready=1 → one cycle of wpcir=0, idexe_bubble=1; next cycle (EXE now bubble) wpcir=1.
- No hazard on $0: same as above but exe_rn=0, id_rs=0 → wpcir=1, idexe_bubble=0.
- Branch during load-use: lduse plus branch_taken=1 → ifid_flush=0 that cycle. Next cycle, with branch_taken=1 and no hazard → ifid_flush=1, wpcir=1.
- Memory wait: mem_m2reg=1, dmem_ready=0 for 3 cycles then 1 → busy_wait=1 for 3 cycles; wpcir=idexe_en=exemem_en=0 and memwb_bubble=1 for those 3 cycles; all enables 1 on the 4th cycle; state RUN afterwards.
- Timeout (MAX_WAIT=15): mem_wmem=1, dmem_ready held 0 → 15 stall cycles; on the 16th cycle memstall=0, then timeout_err=1 and stays 1. Pulse clr → timeout_err=0.
- Reset mid-WAIT: enter WAIT, assert clr for 1 cycle with dmem_ready=0 → state RUN, busy_wait=0, wait_cnt=0. With HAZARD_PERF_CNT_EN defined, stall_cnt=0 after clr.
